// File: rtl/store_buf_pkg.sv
// -----------------------------------------------------------------------------
// store_buf_pkg
// Purpose : Shared defaults and types for the store write buffer.
//           Holds the default geometry (depth, address and data widths), the
//           pointer type and the buffer-entry record for that default build.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package store_buf_pkg;

  localparam int unsigned SWB_DEPTH  = 4;
  localparam int unsigned SWB_ADDR_W = 8;
  localparam int unsigned SWB_DATA_W = 8;
  localparam int unsigned SWB_PTR_W  = $clog2(SWB_DEPTH);

  // Circular-buffer index; wraps naturally because the depth is a power of two.
  typedef logic [SWB_PTR_W-1:0] swb_ptr_t;

  // One buffered store.
  typedef struct packed {
    logic                  valid;
    logic [SWB_ADDR_W-1:0] addr;
    logic [SWB_DATA_W-1:0] data;
  } swb_entry_t;

endpackage

// File: rtl/swb_addr_match.sv
// -----------------------------------------------------------------------------
// swb_addr_match
// Purpose : Combinational lookup of an address against every buffer entry.
//           Returns whether any valid entry matches and the index of the
//           youngest matching entry.
// Ports   :
//   i_lookup_addr  address being searched for
//   i_valid        per-entry valid bits
//   i_addr         per-entry stored addresses
//   i_head         index of the oldest entry
//   o_hit          at least one valid entry matches (full-width compare)
//   o_idx          index of the youngest matching entry (i_head when no hit)
// -----------------------------------------------------------------------------
module swb_addr_match
  import store_buf_pkg::*;
#(
  parameter  int unsigned DEPTH  = SWB_DEPTH,
  parameter  int unsigned ADDR_W = SWB_ADDR_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]             i_lookup_addr,
  input  logic [DEPTH-1:0]              i_valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  i_addr,
  input  logic [PTR_W-1:0]              i_head,
  output logic                          o_hit,
  output logic [PTR_W-1:0]              o_idx
);

  logic [PTR_W-1:0] w_scan_idx;

  // Walk from the oldest entry towards the youngest; a later match overrides
  // an earlier one, which is the same result as searching tail-1 back to head.
  always_comb begin
    o_hit      = 1'b0;
    o_idx      = i_head;
    w_scan_idx = i_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = i_head + PTR_W'(k);
      if (i_valid[w_scan_idx] && (i_addr[w_scan_idx] == i_lookup_addr)) begin
        o_hit = 1'b1;
        o_idx = w_scan_idx;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
// Purpose : Queues stores between the memory stage and the single-ported
//           Data_Mem. Entries drain one per cycle whenever a load does not
//           need the port. Loads are forwarded from the youngest matching
//           entry; on a miss they read Data_Mem combinationally.
// Optional: define STORE_MERGE_EN to let a store overwrite the data of a
//           matching buffered entry instead of pushing a new one.
// Ports   :
//   clk, reset                      clock, synchronous active-high reset
//   cpu_mem_read / cpu_mem_write    load / store request this cycle
//   cpu_address, cpu_write_data     request address and store data
//   cpu_read_data                   load result, same cycle
//   dm_MemRead, dm_MemWrite         Data_Mem strobes
//   dm_Address, dm_Write_data       Data_Mem address / write data
//   dm_Read_data                    Data_Mem read data (combinational)
//   buf_count, buf_empty            occupancy, empty flag
// -----------------------------------------------------------------------------
module store_write_buffer
  import store_buf_pkg::*;
#(
  parameter  int unsigned DEPTH  = SWB_DEPTH,
  parameter  int unsigned ADDR_W = SWB_ADDR_W,
  parameter  int unsigned DATA_W = SWB_DATA_W,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              dm_MemRead,
  output logic              dm_MemWrite,
  output logic [ADDR_W-1:0] dm_Address,
  output logic [DATA_W-1:0] dm_Write_data,
  input  logic [DATA_W-1:0] dm_Read_data,
  output logic [CNT_W-1:0]  buf_count,
  output logic              buf_empty
);

  logic [DEPTH-1:0]             r_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][DATA_W-1:0] r_data;
  logic [PTR_W-1:0]             r_head;
  logic [PTR_W-1:0]             r_tail;
  logic [CNT_W-1:0]             r_count;

  logic             w_hit;
  logic [PTR_W-1:0] w_hit_idx;
  logic             w_load;
  logic             w_load_miss;
  logic             w_pop;
  logic             w_push;
  logic             w_merge;

  // Loads and stores share the same address, so one lookup serves both
  // forwarding and (optional) merging.
  swb_addr_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .i_lookup_addr (cpu_address),
    .i_valid       (r_valid),
    .i_addr        (r_addr),
    .i_head        (r_head),
    .o_hit         (w_hit),
    .o_idx         (w_hit_idx)
  );

  // Read and write together is handled as a plain store.
  assign w_load      = cpu_mem_read & ~cpu_mem_write;
  assign w_load_miss = w_load & ~w_hit;
  // A missing load owns the port; otherwise the head drains if present.
  assign w_pop       = ~w_load_miss & (r_count != '0);

`ifdef STORE_MERGE_EN
  // Merging into the head while it leaves the buffer would lose the store,
  // so that case falls back to a normal push.
  assign w_merge = cpu_mem_write & w_hit & ~(w_pop & (w_hit_idx == r_head));
`else
  assign w_merge = 1'b0;
`endif

  // A store never coincides with a load, so a store into a full buffer is
  // always accompanied by a pop and the count cannot overflow.
  assign w_push = cpu_mem_write & ~w_merge;

  // Control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      // Placed after the pop so a full-buffer push into the slot just freed
      // leaves it valid.
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Entry payload; contents are qualified by r_valid so no reset is needed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_push) begin
        r_addr[r_tail] <= cpu_address;
        r_data[r_tail] <= cpu_write_data;
      end
      if (w_merge) begin
        r_data[w_hit_idx] <= cpu_write_data;
      end
    end
  end

  // Port arbitration and load result.
  always_comb begin
    dm_MemRead    = 1'b0;
    dm_MemWrite   = 1'b0;
    dm_Address    = '0;
    dm_Write_data = '0;
    cpu_read_data = '0;
    if (!reset) begin
      if (w_load_miss) begin
        dm_MemRead    = 1'b1;
        dm_Address    = cpu_address;
        cpu_read_data = dm_Read_data;
      end else begin
        if (w_pop) begin
          dm_MemWrite   = 1'b1;
          dm_Address    = r_addr[r_head];
          dm_Write_data = r_data[r_head];
        end
        // Reaching here with a load means it hit in the buffer.
        if (w_load) begin
          cpu_read_data = r_data[w_hit_idx];
        end
      end
    end
  end

  assign buf_count = reset ? '0 : r_count;
  assign buf_empty = reset | (r_count == '0);

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Sits between the datapath memory-stage signals and Data_Mem.
- Decouples stores from the single data-memory port.
  - Stores are queued in a small circular buffer.
  - The buffer drains one entry per cycle whenever the port is not needed by a load.
- Loads search the buffer first, youngest match wins (store-to-load forwarding); on a miss they read Data_Mem combinationally in the same cycle.

Parameters:
- DEPTH, 4: number of buffered stores; power of two, minimum 2.
- ADDR_W, 8: address width, matching the Data_Mem address port.
- DATA_W, 8: data width, matching the Data_Mem data ports.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  load request this cycle.
- cpu_mem_write  in  1  store request this cycle.
- cpu_address  in  ADDR_W  load/store address.
- cpu_write_data  in  DATA_W  store data.
- cpu_read_data  out  DATA_W  load result, combinational, same cycle.
- dm_MemRead  out  1  to Data_Mem MemRead.
- dm_MemWrite  out  1  to Data_Mem MemWrite.
- dm_Address  out  ADDR_W  to Data_Mem Address.
- dm_Write_data  out  DATA_W  to Data_Mem Write_data.
- dm_Read_data  in  DATA_W  from Data_Mem Read_data; valid combinationally.
- buf_count  out  $clog2(DEPTH)+1  number of valid entries (registered).
- buf_empty  out  1  buf_count==0.

Behaviour:
- Reset (synchronous, active-high):
  - head, tail and count cleared; entry valid bits cleared.
  - While reset is high, all outputs are forced to 0: dm_*, cpu_read_data, buf_count. buf_empty is 1.
  - Reset mid-drain discards all pending stores. This is intentional.
- Port arbitration, per cycle, in priority order:
  - Load miss (cpu_mem_read and no buffer hit): dm_MemRead=1, dm_Address=cpu_address, cpu_read_data=dm_Read_data. No drain this cycle.
  - Otherwise, if count>0: dm_MemWrite=1, dm_Address=head.addr, dm_Write_data=head.data. The head is popped at the clock edge.
  - Otherwise: all dm_* outputs are 0.
- Load hit:
  - cpu_read_data is the data of the youngest valid entry with a matching address.
  - Drain proceeds in parallel.
  - Address compare is on the full ADDR_W bits.
- Store:
  - cpu_mem_write pushes {cpu_address, cpu_write_data} at the tail on the clock edge.
  - The new entry becomes visible to forwarding from the next cycle.
- Full buffer:
  - A store never coincides with a load, so a store to a full buffer always has a same-cycle drain.
  - Pop and push both occur and count is unchanged. There is no stall output.
- Simultaneous push and pop: count unchanged; head and tail both advance.
- Wrap-around: pointers are modulo DEPTH; count distinguishes full from empty.
- Illegal input: cpu_mem_read and cpu_mem_write high together.
  - The block treats it as a store only.
  - cpu_read_data=0.
- Store data wider than DATA_W is the caller's concern; only the low DATA_W bits are held.
- Latency:
  - A load result appears in the same cycle.
  - A store reaches Data_Mem no earlier than 1 cycle after its push. Order is FIFO.

Optional Feature:
- Macro: STORE_MERGE_EN.
- With the macro defined:
  - A store whose address matches a valid entry overwrites that entry's data instead of pushing; count is unchanged.
  - Exception: if the matching entry is the head being drained this cycle, a normal push occurs.
- Without the macro: every store pushes a new entry, and duplicate addresses may coexist.

Decomposition:
- Package store_buf_pkg holds:
  - ADDR_W and DATA_W defaults.
  - A typedef for a buffer entry {valid, addr, data}.
  - A typedef for the pointer type.
- One sub-module, swb_addr_match:
  - Combinational compare of a lookup address against all entries.
  - Returns hit plus the youngest-match index, scanning from tail-1 back to head.

Test Plan:
- Store addr 255 data 0x60, then idle 1 cycle -> dm_MemWrite=1, dm_Address=255, dm_Write_data=0x60 in the cycle after the push; buf_empty=1 afterwards.
- Stores 254←0x7C then 254←0x11, then a load of 254 the next cycle -> cpu_read_data=0x11 from the buffer with no dm_MemRead.
  - With STORE_MERGE_EN: buf_count peaks at 1.
- Load of addr 10 (Data_Mem holds 0x5A) while 2 stores are pending -> dm_MemRead=1, cpu_read_data=0x5A, no drain that cycle, buf_count stays 2.
- 6 back-to-back stores to addresses 0..5 at DEPTH=4 -> all 6 reach Data_Mem in order 0..5; count never exceeds 4; head/tail wrap correctly.
- Reset asserted with 3 pending entries -> next cycle buf_count=0, buf_empty=1, no dm_MemWrite.
- cpu_mem_read and cpu_mem_write both 1 to addr 7, data 0x33 -> entry pushed, cpu_read_data=0, dm_MemRead=0.
